// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the eight-digit seven-segment scanner.
package seg_pkg;

    localparam int DIGITS = 8;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {SHOW, BLANK} scan_state_t;

    // Active-low {g,f,e,d,c,b,a}, entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_scan_ctrl_hex_to_7seg.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan of eight hex digits with blanking gaps and a
// double-buffered load that only commits on a frame boundary.
module seg_scan_ctrl #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 4,
    parameter int DIGITS       = 8
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  enable_mask,
    input  logic        lz_suppress,
    output logic [2:0]  digit_select,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        frame_done
);
    import seg_pkg::*;

    localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int AW   = 4 * DIGITS;

    scan_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_digit;
    logic [AW-1:0] r_active;
    logic [AW-1:0] r_shadow;
    logic          r_full;
    logic [7:0]    r_anode;
    logic [6:0]    r_cathode;
    logic          r_dp;
    logic          r_frame_done;

    logic          w_show_end;
    logic          w_blank_end;
    logic          w_step;
    logic          w_wrap;
    logic          w_supp;
    logic          w_lit;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;

    assign w_show_end  = (r_state == SHOW) && (r_cnt == CW'(PRESCALE - 1));
    assign w_blank_end = (r_state == BLANK) && (r_cnt == CW'(BLANK_CYCLES - 1));
    assign w_step      = (w_show_end && (BLANK_CYCLES == 0)) || w_blank_end;
    assign w_wrap      = w_step && (r_digit == 3'd7);

    assign w_nib  = r_active[{r_digit, 2'b00} +: 4];
    // A digit is a leading zero when it and everything left of it is zero.
    assign w_supp = lz_suppress && (r_digit != 3'd0)
                 && ((r_active >> {r_digit, 2'b00}) == '0);
    assign w_lit  = (r_state == SHOW) && enable_mask[r_digit] && !w_supp;

    hex_to_7seg u_hex (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_state      <= SHOW;
            r_cnt        <= '0;
            r_digit      <= 3'd0;
            r_active     <= '0;
            r_shadow     <= '0;
            r_full       <= 1'b0;
            r_anode      <= 8'hFF;
            r_cathode    <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_anode      <= w_lit ? ~(8'(1) << r_digit) : 8'hFF;
            r_cathode    <= w_lit ? w_seg : SEG_BLANK;
            r_dp         <= w_lit ? ~dp_mask[r_digit] : 1'b1;
            r_frame_done <= w_wrap;
            if (w_step)
                r_digit <= r_digit + 3'd1;
            unique case (r_state)
                SHOW: begin
                    if (w_show_end) begin
                        r_cnt <= '0;
                        if (BLANK_CYCLES != 0)
                            r_state <= BLANK;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                BLANK: begin
                    if (w_blank_end) begin
                        r_cnt   <= '0;
                        r_state <= SHOW;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= SHOW;
            endcase
            // Load and commit are exclusive: ready is low while full.
            if (load_valid && !r_full) begin
                r_shadow <= load_data;
                r_full   <= 1'b1;
            end else if (w_wrap && r_full) begin
                r_active <= r_shadow;
                r_full   <= 1'b0;
            end
        end
    end

    assign load_ready   = ~r_full;
    assign digit_select = r_digit;
    assign anode        = r_anode;
    assign cathode      = r_cathode;
    assign dp           = r_dp;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (with and without blanking)
// checked every cycle against a position-in-frame reference model.
module tb_seg_scan_ctrl;

    localparam int P = 4;
    localparam logic [20:0] RST_E = {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1};

    logic             aclk = 1'b0;
    logic             rst  = 1'b1;
    logic [1:0]       lv   = 2'b00;
    logic [31:0]      ld   = '0;
    logic [7:0]       dpm  = 8'h00;
    logic [7:0]       enm  = 8'hFF;
    logic             lz   = 1'b0;
    logic [1:0]       rdy;
    logic [1:0]       fd;
    logic [1:0][2:0]  ds;
    logic [1:0][7:0]  an;
    logic [1:0][6:0]  ca;
    logic [1:0]       dpo;

    int ncmp = 0;
    int nbad = 0;

    int          k    [2];
    logic [31:0] act  [2];
    logic [31:0] shd  [2];
    bit          full [2];
    logic [20:0] e    [2];

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 aclk = ~aclk;

    seg_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(2), .DIGITS(8)) dut0 (
        .aclk(aclk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]),
        .load_data(ld), .dp_mask(dpm), .enable_mask(enm),
        .lz_suppress(lz), .digit_select(ds[0]), .anode(an[0]),
        .cathode(ca[0]), .dp(dpo[0]), .frame_done(fd[0])
    );

    seg_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(0), .DIGITS(8)) dut1 (
        .aclk(aclk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]),
        .load_data(ld), .dp_mask(dpm), .enable_mask(enm),
        .lz_suppress(lz), .digit_select(ds[1]), .anode(an[1]),
        .cathode(ca[1]), .dp(dpo[1]), .frame_done(fd[1])
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        ncmp++;
        if (got !== req) begin
            nbad++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    task automatic tmo(input string nm);
        ncmp++;
        nbad++;
        $display("FAIL %s: timed out waiting for event", nm);
    endtask

    // Edge k of the run sits at position k mod frame; outputs lag by one.
    task automatic step(input int i);
        int d_len, f_len, p, d;
        bit lit, nf;
        logic [7:0] a;
        logic [6:0] c;
        logic o;
        d_len = P + ((i == 0) ? 2 : 0);
        f_len = 8 * d_len;
        p = k[i] % f_len;
        d = p / d_len;
        lit = ((p % d_len) < P) && enm[d]
           && !(lz && d > 0 && (act[i] >> (4 * d)) == 0);
        a = lit ? ~(8'h01 << d) : 8'hFF;
        c = lit ? HEX[act[i][4*d +: 4]] : 7'h7F;
        o = lit ? ~dpm[d] : 1'b1;
        k[i]++;
        nf = (k[i] % f_len) == 0;
        if (lv[i] && !full[i]) begin
            shd[i] = ld;
            full[i] = 1'b1;
        end else if (nf && full[i]) begin
            act[i] = shd[i];
            full[i] = 1'b0;
        end
        e[i] = {3'((k[i] % f_len) / d_len), a, c, o, nf, !full[i]};
    endtask

    always begin
        @(posedge aclk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                k[i] = 0;
                act[i] = '0;
                shd[i] = '0;
                full[i] = 1'b0;
                e[i] = RST_E;
            end else begin
                step(i);
            end
        end
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("cyc%0d_dut%0d", k[i], i),
                32'({ds[i], an[i], ca[i], dpo[i], fd[i], rdy[i]}),
                32'(e[i]));
    end

    task automatic wait_cyc(input int n);
        while (k[0] < n) @(negedge aclk);
    endtask

    task automatic load(input logic [1:0] m, input logic [31:0] v);
        logic [1:0] pend;
        int n;
        n = 0;
        ld = v;
        lv = m;
        while (lv != 2'b00 && n < 200) begin
            pend = lv & rdy;
            @(negedge aclk);
            lv = lv & ~pend;
            n++;
        end
        if (lv != 2'b00) begin
            tmo("load");
            lv = 2'b00;
        end
    endtask

    initial begin
        int n;
        int r;
        repeat (3) @(negedge aclk);
        chk("rst_ready", 32'(rdy[0]), 1);
        chk("rst_anode", 32'(an[0]), 32'hFF);
        rst = 1'b0;
        wait_cyc(1);
        chk("d0_anode", 32'(an[0]), 32'hFE);
        chk("d0_cath", 32'(ca[0]), 32'h40);
        wait_cyc(5);
        chk("blank_anode", 32'(an[0]), 32'hFF);
        chk("nb_d1_anode", 32'(an[1]), 32'hFD);
        wait_cyc(6);
        chk("ds_step", 32'(ds[0]), 1);
        wait_cyc(10);
        load(2'b11, 32'h89ABCDEF);
        chk("ready_low0", 32'(rdy[0]), 0);
        chk("ready_low1", 32'(rdy[1]), 0);
        wait_cyc(32);
        chk("nb_frame", 32'(fd[1]), 1);
        wait_cyc(33);
        chk("nb_d0_new", 32'(ca[1]), 32'h0E);
        wait_cyc(44);
        chk("old_d7_zero", 32'(ca[0]), 32'h40);
        wait_cyc(47);
        chk("fd_quiet", 32'(fd[0]), 0);
        wait_cyc(48);
        chk("frame_done", 32'(fd[0]), 1);
        chk("ready_back", 32'(rdy[0]), 1);
        wait_cyc(49);
        chk("new_d0_cath", 32'(ca[0]), 32'h0E);
        chk("new_d0_anode", 32'(an[0]), 32'hFE);
        wait_cyc(91);
        chk("new_d7_cath", 32'(ca[0]), 32'h00);
        chk("new_d7_anode", 32'(an[0]), 32'h7F);

        lz = 1'b1;
        load(2'b11, 32'h000000A5);
        wait_cyc(145);
        chk("lz_d0_anode", 32'(an[0]), 32'hFE);
        chk("lz_d0_cath", 32'(ca[0]), 32'h12);
        wait_cyc(151);
        chk("lz_d1_anode", 32'(an[0]), 32'hFD);
        chk("lz_d1_cath", 32'(ca[0]), 32'h08);
        wait_cyc(157);
        chk("lz_d2_dark", 32'(an[0]), 32'hFF);

        wait_cyc(160);
        lz = 1'b0;
        enm = 8'h0F;
        dpm = 8'h02;
        wait_cyc(193);
        chk("dp_d0_off", 32'(dpo[0]), 1);
        chk("en_d0_on", 32'(an[0]), 32'hFE);
        wait_cyc(199);
        chk("dp_d1_on", 32'(dpo[0]), 0);
        chk("en_d1_on", 32'(an[0]), 32'hFD);
        wait_cyc(217);
        chk("en_d4_dark", 32'(an[0]), 32'hFF);
        enm = 8'hFF;
        dpm = 8'h00;

        repeat (300) begin
            @(negedge aclk);
            r = $urandom_range(0, 9);
            if (r == 0) enm = 8'($urandom);
            if (r == 1) dpm = 8'($urandom);
            if (r == 2) lz = 1'($urandom);
            if (r >= 2 && r <= 4)
                load(2'($urandom_range(1, 3)),
                     $urandom >> (4 * $urandom_range(0, 8)));
        end

        enm = 8'hFF;
        dpm = 8'h00;
        lz = 1'b0;
        n = 0;
        while (!fd[0] && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!fd[0]) tmo("frame_done_wait");
        load(2'b01, $urandom | 32'h1);
        n = 0;
        while (ds[0] != 3'd5 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (ds[0] != 3'd5) tmo("digit5_wait");
        chk("full_before_rst", 32'(rdy[0]), 0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_anode", 32'(an[i]), 32'hFF);
            chk("arst_cath", 32'(ca[i]), 32'h7F);
            chk("arst_dp", 32'(dpo[i]), 1);
            chk("arst_ds", 32'(ds[i]), 0);
            chk("arst_ready", 32'(rdy[i]), 1);
        end
        repeat (2) @(negedge aclk);
        rst = 1'b0;
        wait_cyc(1);
        chk("restart_anode", 32'(an[0]), 32'hFE);
        chk("restart_cath", 32'(ca[0]), 32'h40);
        repeat (100) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan controller for the Nexys4 eight-digit seven-segment display. It sequences the anode multiplexer's digit_select, drives active-low anode, cathode and decimal-point lines, and inserts a blanking gap between digits to stop ghosting. A double-buffered load handshake lets the ALU post a new 32-bit value (eight hex nibbles). The new value takes effect only at a frame boundary, so the display never tears.

Parameters:
PRESCALE, 100000, aclk cycles each digit is lit (100 MHz / 100000 = 1 kHz per digit); legal range >= 2
BLANK_CYCLES, 4, aclk cycles with all anodes off between digits; 0 removes the BLANK state entirely
DIGITS, 8, number of digits; fixed at 8 and not intended to be overridden

Ports:
aclk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
load_valid  in  1  load_data is valid
load_ready  out  1  shadow buffer is empty and can accept a value
load_data  in  32  nibble i = load_data[4i+3:4i], digit i; digit 0 is rightmost
dp_mask  in  8  1 = light the decimal point of digit i; sampled live
enable_mask  in  8  0 = digit i is always dark; sampled live
lz_suppress  in  1  1 = blank leading zero digits; sampled live
digit_select  out  3  index of the current digit, fed to the anode multiplexer
anode  out  8  active-low digit enables
cathode  out  7  active-low segments {g,f,e,d,c,b,a}
dp  out  1  active-low decimal point
frame_done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - digit_select=0, anode=8'hFF, cathode=7'h7F, dp=1, frame_done=0.
  - active and shadow registers cleared to 0; shadow marked empty; FSM goes to SHOW with prescale counter = 0.
  - Any pending load is discarded.
- FSM states: SHOW, BLANK.
  - SHOW holds PRESCALE cycles (counter 0..PRESCALE-1). On the last cycle it goes to BLANK, or, if BLANK_CYCLES=0, advances the digit and stays in SHOW.
  - BLANK holds BLANK_CYCLES cycles. On its last cycle: digit_select <= digit_select+1 (wraps 7 -> 0) and the FSM returns to SHOW.
  - One full frame = 8*(PRESCALE+BLANK_CYCLES) cycles.
- All display outputs are registered. They reflect the state and digit of the current cycle, one aclk after a state or digit change.
- In SHOW for digit d, the digit is lit when enable_mask[d]=1 and the digit is not suppressed:
  - anode = ~(8'b1 << d)
  - cathode = hex decode of active nibble d
  - dp = ~dp_mask[d]
- When digit d is not lit (masked or suppressed): anode=8'hFF, cathode=7'h7F, dp=1.
- In BLANK: anode=8'hFF, cathode=7'h7F, dp=1.
- Leading-zero suppression: digit d (d >= 1) is suppressed when lz_suppress=1 and active nibbles d..7 are all zero. Digit 0 is never suppressed.
- Hex decode, active low:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
- Load handshake:
  - load_ready = ~shadow_full, so it is 1 out of reset.
  - A transfer happens on load_valid & load_ready: the shadow captures load_data and shadow_full is set.
  - load_data is ignored when load_ready=0. The producer holds load_valid until the transfer.
- Commit happens at the frame boundary, on the cycle digit_select wraps 7 -> 0:
  - frame_done=1 for exactly that cycle.
  - If shadow_full, active <= shadow and shadow_full is cleared, so load_ready rises the following cycle.
  - A load can never coincide with a commit, because ready is low whenever the shadow is full.
- Back-to-back loads: the second is accepted only after the commit, at most one load per frame. A load is visible within at most one frame plus one digit period.

Decomposition:
- Package seg_pkg holds:
  - DIGITS = 8
  - SEG_BLANK = 7'h7F
  - typedef enum {SHOW, BLANK} scan_state_t
  - the 16-entry hex segment constant table
- Sub-module hex_to_7seg: combinational 4-bit to 7-bit active-low decoder, instantiated once on the muxed active nibble.

Test Plan:
- All tests use PRESCALE=4, BLANK_CYCLES=2 unless stated.
- Reset then idle:
  - load_ready=1; anode=FF during blank cycles.
  - In SHOW, digit 0 shows cathode=40 with anode=FE; digit_select steps 0..7 every 6 cycles.
  - frame_done pulses every 48 cycles.
- Load 32'h89ABCDEF at cycle 10:
  - load_ready drops the next cycle; the display keeps showing zeros until the frame boundary.
  - After frame_done: digit 0 cathode=0E, digit 7 cathode=00; load_ready returns to 1.
- lz_suppress=1, load 32'h0000_00A5:
  - digits 2..7 give anode=FF.
  - digit 1 gives anode=FD, cathode=08.
  - digit 0 gives anode=FE, cathode=12.
- enable_mask=8'h0F, dp_mask=8'h02:
  - digits 4..7 stay dark.
  - dp=0 only while digit_select=1 in SHOW.
- Second load asserted while the shadow is full: stalls (load_ready=0) until frame_done, then transfers. The first value is displayed for exactly one frame.
- Reset asserted mid-SHOW on digit 5 with the shadow full:
  - outputs go to reset values immediately; load_ready=1 after release.
  - The restart begins at digit 0 with active=0.
- Repeat with BLANK_CYCLES=0: no all-off cycles, frame = 32 cycles.
